// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : multicycle_ctrl_if
// Purpose  : Control/status bundle between multicycle_ctrl and the datapath.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             ir_write;
   logic             pc_write;
   logic             pc_src;
   logic             iord;
   logic             alu_src;
   logic [1:0]       alu_op;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             mem_reg;
   logic             instr_done;
   logic             busy;
   logic             illegal;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      input  run, opcode, zero, mem_ready,
      output ir_write, pc_write, pc_src, iord, alu_src, alu_op,
             mem_read, mem_write, reg_write, mem_reg, instr_done,
             busy, illegal, cycle_cnt, instret_cnt
   );

   modport slave (
      output run, opcode, zero, mem_ready,
      input  ir_write, pc_write, pc_src, iord, alu_src, alu_op,
             mem_read, mem_write, reg_write, mem_reg, instr_done,
             busy, illegal, cycle_cnt, instret_cnt
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle RV32 sequencer issuing per-state datapath enables.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input wire               clk,
   input wire               rst,
   multicycle_ctrl_if.master bus
);

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_i      = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_TRAP     = 4'd10
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [6:0]       r_op_q;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;

   logic       w_ir_write, w_pc_write, w_pc_src, w_iord, w_alu_src;
   logic [1:0] w_alu_op;
   logic       w_mem_read, w_mem_write, w_reg_write, w_mem_reg;
   logic       w_instr_done, w_busy, w_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_op_q  <= 7'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_op_q <= bus.opcode;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_iord       = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_op     = 2'b00;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_reg    = 1'b0;
      w_instr_done = 1'b0;
      w_illegal    = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         S_FETCH: begin
            if (bus.run) begin
               w_mem_read = 1'b1;
               if (bus.mem_ready) begin
                  w_ir_write   = 1'b1;
                  w_pc_write   = 1'b1;
                  w_next_state = S_DECODE;
               end
            end else begin
               w_busy = 1'b0;
            end
         end
         // The live opcode is only trusted here; later states look at r_op_q.
         S_DECODE: begin
            case (bus.opcode)
               c_op_r:      w_next_state = S_EXEC_R;
               c_op_i:      w_next_state = S_EXEC_I;
               c_op_load,
               c_op_store:  w_next_state = S_MEM_ADDR;
               c_op_branch: w_next_state = S_BRANCH;
               default:     w_next_state = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            w_alu_op     = 2'b10;
            w_next_state = S_WB_ALU;
         end
         S_EXEC_I: begin
            w_alu_src    = 1'b1;
            w_alu_op     = 2'b10;
            w_next_state = S_WB_ALU;
         end
         S_WB_ALU: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_ADDR: begin
            w_alu_src    = 1'b1;
            w_next_state = (r_op_q == c_op_store) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            if (bus.mem_ready) begin
               w_next_state = S_WB_MEM;
            end
         end
         S_WB_MEM: begin
            w_reg_write  = 1'b1;
            w_mem_reg    = 1'b1;
            w_instr_done = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_WR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            if (bus.mem_ready) begin
               w_instr_done = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_BRANCH: begin
            w_alu_op     = 2'b01;
            w_instr_done = 1'b1;
            w_pc_write   = bus.zero;
            w_pc_src     = bus.zero;
            w_next_state = S_FETCH;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
            w_busy    = 1'b0;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (w_busy) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         end
         if (w_instr_done) begin
            r_instret_cnt <= r_instret_cnt + CNT_W'(1);
         end
      end
   end

   // Reset must silence the datapath immediately, even mid-transfer.
   assign bus.ir_write    = w_ir_write   & ~rst;
   assign bus.pc_write    = w_pc_write   & ~rst;
   assign bus.pc_src      = w_pc_src     & ~rst;
   assign bus.iord        = w_iord       & ~rst;
   assign bus.alu_src     = w_alu_src    & ~rst;
   assign bus.alu_op      = w_alu_op     & {2{~rst}};
   assign bus.mem_read    = w_mem_read   & ~rst;
   assign bus.mem_write   = w_mem_write  & ~rst;
   assign bus.reg_write   = w_reg_write  & ~rst;
   assign bus.mem_reg     = w_mem_reg    & ~rst;
   assign bus.instr_done  = w_instr_done & ~rst;
   assign bus.busy        = w_busy       & ~rst;
   assign bus.illegal     = w_illegal    & ~rst;
   assign bus.cycle_cnt   = r_cycle_cnt;
   assign bus.instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl (4-bit counters).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef logic [13:0] outv_t;
   localparam outv_t O_IRW  = 14'h2000;
   localparam outv_t O_PCW  = 14'h1000;
   localparam outv_t O_PCS  = 14'h0800;
   localparam outv_t O_IORD = 14'h0400;
   localparam outv_t O_ASRC = 14'h0200;
   localparam outv_t O_AFN  = 14'h0100;
   localparam outv_t O_ACMP = 14'h0080;
   localparam outv_t O_MRD  = 14'h0040;
   localparam outv_t O_MWR  = 14'h0020;
   localparam outv_t O_RW   = 14'h0010;
   localparam outv_t O_MREG = 14'h0008;
   localparam outv_t O_DONE = 14'h0004;
   localparam outv_t O_BUSY = 14'h0002;
   localparam outv_t O_ILL  = 14'h0001;

   typedef struct {
      outv_t            o;
      logic [CNT_W-1:0] cyc;
      logic [CNT_W-1:0] ret;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_cyc   = 0;
   int   m_ret   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   wire outv_t act = {bus.ir_write, bus.pc_write, bus.pc_src, bus.iord, bus.alu_src,
                      bus.alu_op, bus.mem_read, bus.mem_write, bus.reg_write,
                      bus.mem_reg, bus.instr_done, bus.busy, bus.illegal};

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // One clock of stimulus plus the outputs the spec demands for it.
   task automatic step(input logic r, input logic [6:0] op, input logic mr,
                       input logic z, input outv_t e, input string nm);
      @(posedge clk);
      #1;
      bus.run       = r;
      bus.opcode    = op;
      bus.mem_ready = mr;
      bus.zero      = z;
      exp_q.push_back('{o: e, cyc: CNT_W'(m_cyc), ret: CNT_W'(m_ret), name: nm});
      if ((e & O_BUSY) != 0) m_cyc = (m_cyc + 1) % (1 << CNT_W);
      if ((e & O_DONE) != 0) m_ret = (m_ret + 1) % (1 << CNT_W);
   endtask

   // Expected per-cycle schedule of a whole instruction by class.
   // abort >= 0 stops a store after that many wait cycles.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                            input logic z, input int abort);
      logic [6:0] junk;
      junk = ~op;
      for (int i = 0; i < fw; i++) step(1'b1, op, 1'b0, z, O_MRD | O_BUSY, "fetch_wait");
      step(1'b1, op, 1'b1, z, O_MRD | O_IRW | O_PCW | O_BUSY, "fetch_ready");
      step(1'b0, op, 1'b1, z, O_BUSY, "decode");
      case (op)
         OP_R: begin
            step(1'b0, junk, 1'b1, z, O_AFN | O_BUSY, "exec_r");
            step(1'b0, junk, 1'b1, z, O_RW | O_DONE | O_BUSY, "wb_alu");
         end
         OP_I: begin
            step(1'b0, junk, 1'b1, z, O_ASRC | O_AFN | O_BUSY, "exec_i");
            step(1'b0, junk, 1'b1, z, O_RW | O_DONE | O_BUSY, "wb_alu");
         end
         OP_LD: begin
            step(1'b0, junk, 1'b1, z, O_ASRC | O_BUSY, "mem_addr");
            for (int i = 0; i < mw; i++)
               step(1'b0, junk, 1'b0, z, O_MRD | O_IORD | O_BUSY, "mem_rd_wait");
            step(1'b0, junk, 1'b1, z, O_MRD | O_IORD | O_BUSY, "mem_rd_ready");
            step(1'b0, junk, 1'b1, z, O_RW | O_MREG | O_DONE | O_BUSY, "wb_mem");
         end
         OP_ST: begin
            step(1'b0, junk, 1'b1, z, O_ASRC | O_BUSY, "mem_addr");
            if (abort >= 0) begin
               for (int i = 0; i < abort; i++)
                  step(1'b0, junk, 1'b0, z, O_MWR | O_IORD | O_BUSY, "mem_wr_wait");
            end else begin
               for (int i = 0; i < mw; i++)
                  step(1'b0, junk, 1'b0, z, O_MWR | O_IORD | O_BUSY, "mem_wr_wait");
               step(1'b0, junk, 1'b1, z, O_MWR | O_IORD | O_DONE | O_BUSY, "mem_wr_ready");
            end
         end
         OP_BR: begin
            step(1'b0, junk, 1'b1, z,
                 O_ACMP | O_DONE | O_BUSY | (z ? (O_PCW | O_PCS) : outv_t'(0)), "branch");
         end
         default: begin
            for (int i = 0; i < 3; i++) step(1'b1, junk, 1'b1, z, O_ILL, "trap");
         end
      endcase
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      bus.run = 1'b1;
      #1;
      check("rst_outputs_zero", 32'(act), 32'd0);
      check("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bus.run = 1'b0;
      m_cyc   = 0;
      m_ret   = 0;
   endtask

   always @(negedge clk) begin : p_compare
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.name, "/outputs"}, 32'(act), 32'(e.o));
         check({e.name, "/cycle_cnt"}, 32'(bus.cycle_cnt), 32'(e.cyc));
         check({e.name, "/instret_cnt"}, 32'(bus.instret_cnt), 32'(e.ret));
      end
   end

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : p_main
      bus.run = 1'b1; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      #1 rst = 1'b1;
      #11;
      check("por_outputs_zero", 32'(act), 32'd0);
      check("por_instret_cnt", 32'(bus.instret_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.run = 1'b0;

      // ADD, then an I-type with a fetch wait, then a load with two waits
      run_instr(OP_R, 0, 0, 1'b0, -1);
      step(1'b0, 7'd0, 1'b1, 1'b0, '0, "idle");
      @(negedge clk); #1;
      check("add_cycle_cnt", 32'(bus.cycle_cnt), 32'd4);
      check("add_instret_cnt", 32'(bus.instret_cnt), 32'd1);
      run_instr(OP_I, 1, 0, 1'b1, -1);
      run_instr(OP_LD, 0, 2, 1'b0, -1);
      step(1'b0, 7'd0, 1'b1, 1'b0, '0, "idle");
      @(negedge clk); #1;
      check("load_cycle_cnt_wrapped", 32'(bus.cycle_cnt), 32'd0);
      check("load_instret_cnt", 32'(bus.instret_cnt), 32'd3);

      run_instr(OP_ST, 0, 1, 1'b0, -1);
      run_instr(OP_BR, 0, 0, 1'b1, -1);
      run_instr(OP_BR, 0, 0, 1'b0, -1);
      step(1'b0, 7'd0, 1'b0, 1'b0, '0, "idle");

      // Asynchronous reset while a store waits on memory
      run_instr(OP_ST, 0, 5, 1'b0, 2);
      @(negedge clk); #1;
      check("st_wait_mem_write", 32'(bus.mem_write), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("async_rst_iord", 32'(bus.iord), 32'd0);
      check("async_rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; bus.run = 1'b0; m_cyc = 0; m_ret = 0;
      step(1'b0, 7'd0, 1'b1, 1'b0, '0, "idle_after_rst");

      // Illegal opcode traps and freezes the cycle counter
      run_instr(OP_BAD, 0, 0, 1'b0, -1);
      @(negedge clk); #1;
      check("trap_illegal", 32'(bus.illegal), 32'd1);
      check("trap_busy", 32'(bus.busy), 32'd0);
      check("trap_cycle_cnt_frozen", 32'(bus.cycle_cnt), 32'd2);
      apply_reset();
      check("post_rst_illegal", 32'(bus.illegal), 32'd0);

      // 16 back-to-back R-types wrap both 4-bit counters
      for (int i = 0; i < 16; i++) begin
         run_instr(OP_R, 0, 0, 1'b0, -1);
         if (i == 14) begin
            @(posedge clk); #2;
            check("wrap_instret_15", 32'(bus.instret_cnt), 32'd15);
            check("wrap_cycle_12", 32'(bus.cycle_cnt), 32'd12);
         end
      end
      step(1'b0, 7'd0, 1'b1, 1'b0, '0, "idle");
      @(negedge clk); #1;
      check("wrap_instret_0", 32'(bus.instret_cnt), 32'd0);
      check("wrap_cycle_0", 32'(bus.cycle_cnt), 32'd0);

      @(negedge clk); #1;
      if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
